fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter sharing the single `winc`/`wdata` write port of the asynchronous FIFO among NREQ requesters in the write clock domain. Each requester owns the port for a burst of up to BURST words, then ownership rotates. The block sits directly in front of the FIFO write side. It consumes the FIFO's `wfull` as backpressure, so no requester ever writes into a full FIFO.

## Interface
- DSIZE, 8, data word width; matches FIFO DSIZE
- NREQ, 4, number of requesters; 2..8
- BURST, 4, maximum words accepted per grant; ≥1
- wclk  input  1  write-domain clock; all logic on rising edge
- wrst  input  1  reset, synchronous, active-high
- req  input  NREQ  per-requester word-valid; bit i has a word on reqdata slice i
- reqdata  input  NREQ*DSIZE  requester data, slice i = [i*DSIZE +: DSIZE]
- wfull  input  1  FIFO full flag, write domain
- ack  output  NREQ  one-hot; bit i high means requester i's word is consumed this cycle
- gnt  output  NREQ  one-hot registered current owner; all-zero when idle
- winc  output  1  FIFO write enable
- wdata  output  DSIZE  FIFO write data
- busy  output  1  high while a grant is held

## Operation
- Registered state: `state` (IDLE, GRANT), `gnt`, `owner` index, rotation pointer `ptr` (0..NREQ-1), beat counter `cnt` (width clog2(BURST+1)).
- Reset values: state=IDLE, gnt=0, owner=0, ptr=0, cnt=0; hence busy=0, winc=0, ack=0. wdata is don't-care but driven from the slice of owner 0.
- IDLE: if any req bit is set, select the first set bit searching ptr, ptr+1, …, wrapping mod NREQ. Register gnt/owner to it, set cnt=0, go to GRANT. If no req bit is set, stay in IDLE.
- GRANT, combinational:
  - winc = req[owner] & ~wfull & ~wrst
  - ack = winc ? onehot(owner) : 0
  - wdata = reqdata slice owner, unregistered
- GRANT, per edge:
  - if winc, cnt increments.
  - Release when winc and cnt==BURST-1 (BURST-th word), or when req[owner]==0.
  - On release: next state IDLE, gnt=0, cnt=0, ptr = (owner+1) mod NREQ.
- wfull stall: while req[owner]=1 and wfull=1, hold the grant, cnt unchanged, no timeout. A requester dropping req while stalled releases the grant normally.
- A requester must hold req and its data stable until it sees ack; it may change data in the cycle after ack.
- Reset mid-burst: winc/ack are forced low in any cycle with wrst=1. The next edge returns to reset values, so no partial or duplicate write is produced.
- busy = (state==GRANT) = |gnt.

## Timing
- Arbitration latency: req rises in cycle 0 while IDLE, gnt is high in cycle 1, and the first winc is in cycle 1 if wfull=0.
- Throughput inside a grant: one word per cycle while req[owner]=1 and wfull=0.
- Handover: last accepted word in cycle k; cycle k+1 is IDLE with gnt=0; the next gnt is in cycle k+2. This gives one dead cycle per handover.
- Per-burst maximum is BURST words over BURST cycles unstalled.
- Fairness: every continuously requesting requester gets a grant within NREQ-1 intervening grants.
- wfull must be the FIFO's registered flag. winc depends combinationally on wfull in the same cycle.

## Test plan
- Reset: hold wrst=1 for 3 cycles with req=4'b1111 → gnt=0, winc=0, ack=0, busy=0 throughout. The first gnt=4'b0001 appears one cycle after wrst falls.
- Round-robin with BURST=4: all four requesters held high with distinct data, wfull=0 → gnt sequence 0001, 0010, 0100, 1000, 0001. Each grant gives exactly 4 winc pulses, then one idle cycle. The FIFO receives words in requester order.
- Early release: requester 2 alone asserts req for 2 words → 2 acks, gnt drops the cycle after req falls, and ptr becomes 3. Then req={0,1} → requester 0 granted? No: the search starts at ptr=3, wraps to 0, so gnt=0001.
- Backpressure: wfull=1 for 5 cycles mid-burst after 1 word → winc=0 and ack=0 for 5 cycles, gnt held, cnt holds at 1. After wfull falls, exactly 3 more words are written.
- Reset mid-burst: assert wrst in the cycle of the 2nd word with req and wfull=0 → no winc that cycle. All reset values appear the next cycle, and the total word count written is 1.
- Single requester streaming 10 words, BURST=4 → winc pattern 4 on, 1 off, 4 on, 1 off, 2 on. Data order is preserved.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Each grant accepts up to BURST words; wfull stalls the owner without releasing it.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] reqdata,
  input  logic                  wfull,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (BURST > 0) ? $clog2(BURST + 1) : 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     sel_idx;
  logic              sel_found;
  logic              last_beat;
  logic              rel;

  // Search ptr, ptr+1, ... wrapping; iterate downward so the nearest set bit wins.
  always_comb begin
    logic [OW-1:0] idx;
    idx       = '0;
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = OW'((int'(ptr_q) + k) % int'(NREQ));
      if (req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  assign winc      = (state_q == StGrant) & req[owner_q] & ~wfull & ~wrst;
  assign wdata     = reqdata[int'(owner_q) * int'(DSIZE) +: DSIZE];
  assign last_beat = winc & (cnt_q == CW'(BURST - 1));
  assign rel       = last_beat | ~req[owner_q];
  assign gnt       = gnt_q;
  assign busy      = (state_q == StGrant);

  always_comb begin
    ack = '0;
    if (winc) ack[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d        = StGrant;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          owner_d        = sel_idx;
          cnt_d          = '0;
        end
      end
      StGrant: begin
        if (winc) cnt_d = cnt_q + 1'b1;
        if (rel) begin
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, rotation, early release, stall,
// reset mid-burst and single-requester streaming, with a captured FIFO image.
module tb_fifo_wr_arbiter;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 4;

  logic                  wclk;
  logic                  wrst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] reqdata;
  logic                  wfull;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [DSIZE-1:0] fifo_q[$];

  fifo_wr_arbiter #(
    .DSIZE(DSIZE),
    .NREQ (NREQ),
    .BURST(BURST)
  ) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .req    (req),
    .reqdata(reqdata),
    .wfull  (wfull),
    .ack    (ack),
    .gnt    (gnt),
    .winc   (winc),
    .wdata  (wdata),
    .busy   (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Image of what the FIFO would store.
  always @(posedge wclk) if (winc === 1'b1) fifo_q.push_back(wdata);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  // Sample one cycle's outputs mid-cycle, then advance past the next edge.
  task automatic cycle(input string tag, input logic [3:0] g, input logic w,
                       input logic [7:0] d);
    @(negedge wclk);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".winc"}, 32'(winc), 32'(w));
    check({tag, ".ack"}, 32'(ack), w ? 32'(g) : 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'(|g));
    if (w) check({tag, ".wdata"}, 32'(wdata), 32'(d));
    next_cycle();
  endtask

  task automatic do_reset();
    req  = '0;
    wfull = 1'b0;
    wrst = 1'b1;
    next_cycle();
    wrst = 1'b0;
    fifo_q.delete();
  endtask

  logic [11:0] pat;
  int          nacc;

  initial begin
    wrst  = 1'b1;
    wfull = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < NREQ; i++) reqdata[i*DSIZE +: DSIZE] = 8'hA0 + 8'(i);
    next_cycle();
    fifo_q.delete();

    // Reset held with all requesters active
    for (int i = 0; i < 3; i++) cycle($sformatf("rst%0d", i), 4'b0000, 1'b0, 8'h00);
    wrst = 1'b0;
    cycle("rst_fall", 4'b0000, 1'b0, 8'h00);

    // Round-robin, all requesters continuously active
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++)
        cycle($sformatf("rr_g%0d_b%0d", g, b), 4'(1 << g), 1'b1, 8'hA0 + 8'(g));
      cycle($sformatf("rr_idle%0d", g), 4'b0000, 1'b0, 8'h00);
    end
    cycle("rr_wrap", 4'b0001, 1'b1, 8'hA0);
    check("rr_count", 32'(fifo_q.size()), 32'd17);
    for (int k = 0; k < 17 && k < fifo_q.size(); k++)
      check($sformatf("rr_fifo%0d", k), 32'(fifo_q[k]), 32'(8'hA0 + 8'((k / 4) % 4)));

    // Early release by requester 2, then wrap from ptr=3
    do_reset();
    req = 4'b0100;
    cycle("er_idle", 4'b0000, 1'b0, 8'h00);
    cycle("er_w0", 4'b0100, 1'b1, 8'hA2);
    cycle("er_w1", 4'b0100, 1'b1, 8'hA2);
    req = 4'b0000;
    cycle("er_drop", 4'b0100, 1'b0, 8'h00);
    req = 4'b0011;
    cycle("er_rel", 4'b0000, 1'b0, 8'h00);
    cycle("er_wrap", 4'b0001, 1'b1, 8'hA0);
    check("er_count", 32'(fifo_q.size()), 32'd3);

    // Backpressure after one word
    do_reset();
    req = 4'b0001;
    cycle("bp_idle", 4'b0000, 1'b0, 8'h00);
    cycle("bp_w0", 4'b0001, 1'b1, 8'hA0);
    wfull = 1'b1;
    for (int i = 0; i < 5; i++) cycle($sformatf("bp_stall%0d", i), 4'b0001, 1'b0, 8'h00);
    check("bp_count_stall", 32'(fifo_q.size()), 32'd1);
    wfull = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("bp_w%0d", i + 1), 4'b0001, 1'b1, 8'hA0);
    cycle("bp_rel", 4'b0000, 1'b0, 8'h00);
    check("bp_count", 32'(fifo_q.size()), 32'd4);

    // Reset in the cycle of the second word
    do_reset();
    req = 4'b0001;
    cycle("rm_idle", 4'b0000, 1'b0, 8'h00);
    cycle("rm_w0", 4'b0001, 1'b1, 8'hA0);
    wrst = 1'b1;
    cycle("rm_rst", 4'b0001, 1'b0, 8'h00);
    wrst = 1'b0;
    cycle("rm_after", 4'b0000, 1'b0, 8'h00);
    check("rm_count", 32'(fifo_q.size()), 32'd1);

    // Single requester streams 10 words: 4 on, 1 off, 4 on, 1 off, 2 on
    do_reset();
    pat  = 12'b1101_1110_1111;
    nacc = 0;
    reqdata[0 +: DSIZE] = 8'h00;
    req = 4'b0001;
    cycle("st_idle", 4'b0000, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      reqdata[0 +: DSIZE] = 8'(nacc);
      cycle($sformatf("st%0d", i), pat[i] ? 4'b0001 : 4'b0000, pat[i], 8'(nacc));
      if (pat[i]) nacc++;
    end
    req = 4'b0000;
    cycle("st_drop", 4'b0001, 1'b0, 8'h00);
    cycle("st_end", 4'b0000, 1'b0, 8'h00);
    check("st_count", 32'(fifo_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < fifo_q.size(); k++)
      check($sformatf("st_fifo%0d", k), 32'(fifo_q[k]), 32'(k));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
